// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: 50%-duty clk_out with glitch-free start/stop and
// period-aligned divisor updates. Define PERIOD_MEAS_EN to build the probe period meter.
module clk_div_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [CNT_W-1:0] half_period_in,
    output logic             load_ack,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             busy,
    input  logic             probe,
    output logic             meas_valid,
    output logic [CNT_W:0]   meas_cycles
);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] half_reg, half_next;
    logic [CNT_W-1:0] pend_reg, pend_next;
    logic             pend_valid_reg, pend_valid_next;
    logic             applied_reg, applied_next;
    logic             clk_out_next, rise_next, cfg_err_next;
    logic             load_ok, terminal;

    assign load_ok  = load && (half_period_in != '0);
    assign terminal = (cnt_reg == half_reg - CNT_W'(1));
    assign busy     = (state_reg != IDLE);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        half_next       = half_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        applied_next    = 1'b0;
        clk_out_next    = clk_out;
        rise_next       = 1'b0;
        cfg_err_next    = cfg_err;

        if (load) begin
            cfg_err_next = !load_ok;
        end

        case (state_reg)
            IDLE: begin
                clk_out_next = 1'b0;
                cnt_next     = '0;
                // Nothing is toggling, so a new divisor can take effect right away.
                if (load_ok) begin
                    half_next       = half_period_in;
                    pend_valid_next = 1'b0;
                    applied_next    = 1'b1;
                end else if (pend_valid_reg) begin
                    half_next       = pend_reg;
                    pend_valid_next = 1'b0;
                    applied_next    = 1'b1;
                end
                if (start && !stop) begin
                    state_next = RUN;
                end
            end
            RUN, STOPPING: begin
                if (state_reg == STOPPING && !clk_out) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    if (terminal) begin
                        cnt_next     = '0;
                        clk_out_next = !clk_out;
                        rise_next    = !clk_out;
                        // Falling toggle closes a full period: swap in the staged divisor.
                        if (clk_out) begin
                            if (pend_valid_reg) begin
                                half_next       = pend_reg;
                                pend_valid_next = 1'b0;
                                applied_next    = 1'b1;
                            end
                            if (state_reg == STOPPING) begin
                                state_next = IDLE;
                            end
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (state_reg == RUN && stop) begin
                        state_next = STOPPING;
                    end
                end
                // Staged after any apply above, so a load on the apply edge waits a period.
                if (load_ok) begin
                    pend_next       = half_period_in;
                    pend_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            half_reg       <= CNT_W'(DEFAULT_HALF);
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            applied_reg    <= 1'b0;
            load_ack       <= 1'b0;
            cfg_err        <= 1'b0;
            clk_out        <= 1'b0;
            rise_pulse     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            half_reg       <= half_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            applied_reg    <= applied_next;
            load_ack       <= applied_reg;
            cfg_err        <= cfg_err_next;
            clk_out        <= clk_out_next;
            rise_pulse     <= rise_next;
        end
    end

`ifdef PERIOD_MEAS_EN
    logic [2:0]     probe_sync_reg;
    logic           seen_edge_reg;
    logic [CNT_W:0] meas_cnt_reg;
    logic           probe_rise;

    // Bits [1:0] are the synchroniser; bit 2 is the previous sample for edge detect.
    assign probe_rise = probe_sync_reg[1] && !probe_sync_reg[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            probe_sync_reg <= '0;
            seen_edge_reg  <= 1'b0;
            meas_cnt_reg   <= '0;
            meas_valid     <= 1'b0;
            meas_cycles    <= '0;
        end else begin
            probe_sync_reg <= {probe_sync_reg[1:0], probe};
            meas_valid     <= 1'b0;
            if (probe_rise) begin
                seen_edge_reg <= 1'b1;
                meas_cnt_reg  <= (CNT_W+1)'(1);
                if (seen_edge_reg) begin
                    meas_cycles <= meas_cnt_reg;
                    meas_valid  <= 1'b1;
                end
            end else if (meas_cnt_reg != '1) begin
                meas_cnt_reg <= meas_cnt_reg + (CNT_W+1)'(1);
            end
        end
    end
`else
    logic probe_unused;
    assign probe_unused = probe;
    assign meas_valid   = 1'b0;
    assign meas_cycles  = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, directed corner sequences,
// and randomized stimulus against a period-position reference model.
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             load;
    logic [CNT_W-1:0] half_period_in;
    logic             load_ack;
    logic             cfg_err;
    logic             clk_out;
    logic             rise_pulse;
    logic             busy;
    logic             probe;
    logic             meas_valid;
    logic [CNT_W:0]   meas_cycles;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .load           (load),
        .half_period_in (half_period_in),
        .load_ack       (load_ack),
        .cfg_err        (cfg_err),
        .clk_out        (clk_out),
        .rise_pulse     (rise_pulse),
        .busy           (busy),
        .probe          (probe),
        .meas_valid     (meas_valid),
        .meas_cycles    (meas_cycles)
    );

    assign probe = clk_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int half_in;
        bit exp_err;
        int exp_rise;
        int exp_period;
    } vec_t;

    vec_t vecs[6];

    // Reference model: position within the current output period.
    int   m_mode;
    int   m_pos;
    int   m_h;
    bit   m_clk, m_rise, m_ack, m_err, m_applied_prev;
    int   m_pend[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0; stop = 1'b0; load = 1'b0; half_period_in = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_load(input int v);
        load = 1'b1;
        half_period_in = CNT_W'(v);
        tick();
        load = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic measure_rise(output int k);
        k = 0;
        while (clk_out !== 1'b1 && k < 1000) begin
            tick();
            k++;
        end
    endtask

    task automatic measure_period(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (rise_pulse !== 1'b1 && k < 1000);
    endtask

    task automatic stop_run();
        int k;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 2000) begin
            tick();
            k++;
        end
        chk("stop_reaches_idle", busy, 0);
        chk("stop_clk_low", clk_out, 0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_h = 10;
        m_clk = 0; m_rise = 0; m_ack = 0; m_err = 0; m_applied_prev = 0;
        m_pend.delete();
    endtask

    task automatic model_step(input bit st, input bit sp, input bit ld, input int hin);
        bit applied;
        applied = 0;
        m_rise = 0;
        m_ack = m_applied_prev;
        if (ld) m_err = (hin == 0);
        if (m_mode == 0) begin
            m_clk = 0;
            m_pos = 0;
            if (ld && hin != 0) begin
                m_h = hin; applied = 1; m_pend.delete();
            end else if (m_pend.size() > 0) begin
                m_h = m_pend.pop_front(); applied = 1;
            end
            if (st && !sp) m_mode = 1;
        end else begin
            if (m_mode == 2 && !m_clk) begin
                m_mode = 0;
                m_pos = 0;
            end else begin
                m_pos++;
                if (m_pos == m_h) begin
                    m_clk = 1; m_rise = 1;
                end else if (m_pos == 2 * m_h) begin
                    m_clk = 0; m_pos = 0;
                    if (m_pend.size() > 0) begin
                        m_h = m_pend.pop_front(); applied = 1;
                    end
                    if (m_mode == 2) m_mode = 0;
                end
                if (m_mode == 1 && sp) m_mode = 2;
            end
            if (ld && hin != 0) begin
                m_pend.delete();
                m_pend.push_back(hin);
            end
        end
        m_applied_prev = applied;
    endtask

    initial begin
        int k, t, acks, rises, bad;
        bit st, sp, ld;
        int hin;

        vecs[0] = '{0,  1'b1, 10, 20};
        vecs[1] = '{5,  1'b0, 5,  10};
        vecs[2] = '{1,  1'b0, 1,  2};
        vecs[3] = '{0,  1'b1, 1,  2};
        vecs[4] = '{3,  1'b0, 3,  6};
        vecs[5] = '{12, 1'b0, 12, 24};

        // Reset state
        rst = 1'b0;
        start = 1'b0; stop = 1'b0; load = 1'b0; half_period_in = '0;
        #2;
        chk("reset_clk_out", clk_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_load_ack", load_ack, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_rise", rise_pulse, 0);
        chk("reset_meas_valid", meas_valid, 0);
        do_reset();

        // Vector table: load in IDLE, then start and measure.
        for (int i = 0; i < 6; i++) begin
            pulse_load(vecs[i].half_in);
            chk("vec_cfg_err", cfg_err, vecs[i].exp_err);
            acks = load_ack;
            tick(); acks += load_ack;
            tick(); acks += load_ack;
            chk("vec_ack_count", acks, vecs[i].exp_err ? 0 : 1);
            start_run();
            chk("vec_busy", busy, 1);
            measure_rise(k);
            chk("vec_first_rise", k, vecs[i].exp_rise);
            chk("vec_rise_pulse", rise_pulse, 1);
            measure_period(t);
            chk("vec_period", t, vecs[i].exp_period);
            $display("vec %0d: half_in=%0d cfg_err=%0d rise=%0d period=%0d", i, vecs[i].half_in, cfg_err, k, t);
            stop_run();
        end

        // Divisor change mid-run takes effect only after the current period.
        do_reset();
        start_run();
        measure_rise(k);
        chk("t2_first_rise", k, 10);
        t = 0;
        repeat (3) begin tick(); t++; end
        pulse_load(5); t++;
        chk("t2_no_early_ack", load_ack, 0);
        while (clk_out === 1'b1 && t < 100) begin tick(); t++; end
        chk("t2_high_len", t, 10);
        chk("t2_ack_at_fall", load_ack, 0);
        tick(); chk("t2_ack_pulse", load_ack, 1);
        tick(); chk("t2_ack_clear", load_ack, 0);
        k = 2;
        while (clk_out !== 1'b1 && k < 100) begin tick(); k++; end
        chk("t2_new_low_len", k, 5);
        measure_period(t); chk("t2_new_period", t, 10);
        measure_period(t); chk("t2_new_period2", t, 10);
        $display("t2: load 5 mid-period applied at boundary, period=%0d", t);

        // Zero load rejected while running; nonzero load then clears the error.
        pulse_load(0);
        chk("t3_cfg_err_set", cfg_err, 1);
        acks = 0;
        for (int i = 0; i < 15; i++) begin tick(); acks += load_ack; end
        chk("t3_no_ack", acks, 0);
        measure_period(t); measure_period(t);
        chk("t3_period_unchanged", t, 10);
        pulse_load(3);
        chk("t3_cfg_err_clear", cfg_err, 0);
        k = 0;
        while (load_ack !== 1'b1 && k < 50) begin tick(); k++; end
        chk("t3_ack_seen", load_ack, 1);
        measure_period(t);
        measure_period(t);
        chk("t3_period_6", t, 6);
        $display("t3: zero load rejected, load 3 period=%0d", t);

        // Stop during high phase: high phase completes, no truncation.
        measure_period(t);
        t = 0;
        tick(); t++;
        stop = 1'b1; tick(); t++; stop = 1'b0;
        while (clk_out === 1'b1 && t < 100) begin tick(); t++; end
        chk("t4_high_full", t, 3);
        tick();
        chk("t4_busy_low", busy, 0);
        chk("t4_clk_low", clk_out, 0);
        rises = 0;
        for (int i = 0; i < 10; i++) begin tick(); rises += rise_pulse; end
        chk("t4_no_rise_after", rises, 0);

        // Stop during low phase: IDLE next cycle, no runt pulse.
        start_run();
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        chk("t4_low_idle", busy, 0);
        chk("t4_low_clk", clk_out, 0);
        rises = 0;
        for (int i = 0; i < 10; i++) begin tick(); rises += rise_pulse + clk_out; end
        chk("t4_low_no_runt", rises, 0);
        $display("t4: stop in high and low phases handled");

        // start & stop together in IDLE.
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("t5_startstop_idle", busy, 0);
        rises = 0;
        for (int i = 0; i < 8; i++) begin tick(); rises += clk_out; end
        chk("t5_startstop_clk", rises, 0);

        // Async reset mid-high drops clk_out at once and discards pending.
        start_run();
        measure_rise(k);
        tick();
        pulse_load(7);
        chk("t5_high_before_rst", clk_out, 1);
        rst = 1'b0;
        #1;
        chk("t5_async_clk_low", clk_out, 0);
        chk("t5_async_busy_low", busy, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        start_run();
        measure_rise(k);
        chk("t5_default_after_rst", k, 10);
        $display("t5: async reset mid-high, restart rise=%0d", k);

`ifdef PERIOD_MEAS_EN
        // Meter with probe = clk_out, half 10.
        begin
            int last;
            int got;
            last = -1;
            got = 0;
            k = 0;
            while (got < 3 && k < 300) begin
                tick(); k++;
                if (meas_valid === 1'b1) begin
                    chk("t6_meas_cycles", meas_cycles, 20);
                    if (last >= 0) chk("t6_valid_gap", k - last, 20);
                    last = k;
                    got++;
                    $display("t6: meas_valid at %0d meas_cycles=%0d", k, meas_cycles);
                end
            end
            chk("t6_valid_count", got, 3);
        end
`else
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (meas_valid !== 1'b0 || meas_cycles !== '0) bad++;
        end
        chk("t6_meter_off", bad, 0);
        $display("t6: meter disabled, outputs held 0");
`endif
        stop_run();

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            st  = ($urandom_range(7) == 0);
            sp  = ($urandom_range(49) == 0);
            ld  = ($urandom_range(24) == 0);
            hin = $urandom_range(4);
            start = st; stop = sp; load = ld; half_period_in = CNT_W'(hin);
            if (ld) $display("rand cyc %0d: load %0d", cyc, hin);
            tick();
            model_step(st, sp, ld, hin);
            chk("rand_clk_out", clk_out, m_clk);
            chk("rand_rise", rise_pulse, m_rise);
            chk("rand_busy", busy, (m_mode != 0));
            chk("rand_load_ack", load_ack, m_ack);
            chk("rand_cfg_err", cfg_err, m_err);
        end
        start = 1'b0; stop = 1'b0; load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
